// File: rtl/writeback_buffer.sv
// Writeback buffer: queues ALU and load results in program order and drives the
// register file write port one entry per cycle, forwarding queued data to decode.
module writeback_buffer #(
   parameter int DEPTH = 4,
   parameter int AW    = 6,
   parameter int DW    = 32
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     alu_valid,
   input  logic [AW-1:0]            alu_rd,
   input  logic [DW-1:0]            alu_data,
   input  logic                     mem_valid,
   input  logic [AW-1:0]            mem_rd,
   input  logic [DW-1:0]            mem_data,
   output logic                     mem_ready,
   output logic                     RegWrite,
   output logic [AW-1:0]            RD,
   output logic [DW-1:0]            WriteData,
   input  logic [AW-1:0]            Read1,
   input  logic [AW-1:0]            Read2,
   output logic                     Fwd1Valid,
   output logic [DW-1:0]            Fwd1Data,
   output logic                     Fwd2Valid,
   output logic [DW-1:0]            Fwd2Data,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic [AW-1:0] rd;
      logic [DW-1:0] data;
   } entry_t;

   entry_t          mem_q [DEPTH];
   logic [CW-1:0]   count_q, count_d, avail;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, alu_ptr;
   logic            regwrite_q;
   logic [AW-1:0]   rd_out_q;
   logic [DW-1:0]   wdata_q;
   logic            pop, alu_acc, mem_acc, enq_mem, enq_alu;

   logic [1:0][AW-1:0] look_addr;
   logic [1:0]         fwd_valid;
   logic [1:0][DW-1:0] fwd_data;
   logic [PW-1:0]      idx;

   // Space is judged after this cycle's pop, so the ALU always fits and the
   // load path is only refused when both results would not fit together.
   always_comb begin
      pop       = (count_q != '0);
      avail     = CW'(DEPTH) - (count_q - CW'(pop));
      alu_acc   = alu_valid && (alu_rd != '0);
      mem_ready = (avail >= CW'(2)) || !alu_acc;
      mem_acc   = mem_valid && mem_ready;
      enq_mem   = mem_acc && (mem_rd != '0);
      enq_alu   = alu_acc;
      alu_ptr   = wr_ptr_q + PW'(enq_mem);
      wr_ptr_d  = alu_ptr + PW'(enq_alu);
      rd_ptr_d  = rd_ptr_q + PW'(pop);
      count_d   = count_q + CW'(enq_mem) + CW'(enq_alu) - CW'(pop);
   end

   // NOTE: entry storage has no reset; count and the pointers alone decide which
   // entries are live, so stale contents are never observed.
   always_ff @(posedge clock) begin
      if (enq_mem) mem_q[wr_ptr_q] <= '{rd: mem_rd, data: mem_data};
      if (enq_alu) mem_q[alu_ptr]  <= '{rd: alu_rd, data: alu_data};
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         regwrite_q <= 1'b0;
         rd_out_q   <= '0;
         wdata_q    <= '0;
      end else begin
         count_q    <= count_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         regwrite_q <= pop;
         if (pop) begin
            rd_out_q <= mem_q[rd_ptr_q].rd;
            wdata_q  <= mem_q[rd_ptr_q].data;
         end
      end
   end

   assign look_addr[0] = Read1;
   assign look_addr[1] = Read2;

   // Scan oldest to youngest (output stage, then head to tail); the last hit wins.
   always_comb begin
      fwd_valid = '0;
      fwd_data  = '0;
      idx       = '0;
      for (int p = 0; p < 2; p++) begin
         if (look_addr[p] != '0) begin
            if (regwrite_q && (rd_out_q == look_addr[p])) begin
               fwd_valid[p] = 1'b1;
               fwd_data[p]  = wdata_q;
            end
            for (int i = 0; i < DEPTH; i++) begin
               idx = rd_ptr_q + PW'(i);
               if ((CW'(i) < count_q) && (mem_q[idx].rd == look_addr[p])) begin
                  fwd_valid[p] = 1'b1;
                  fwd_data[p]  = mem_q[idx].data;
               end
            end
         end
      end
   end

   assign RegWrite  = regwrite_q;
   assign RD        = rd_out_q;
   assign WriteData = wdata_q;
   assign Fwd1Valid = fwd_valid[0];
   assign Fwd1Data  = fwd_data[0];
   assign Fwd2Valid = fwd_valid[1];
   assign Fwd2Data  = fwd_data[1];
   assign count     = count_q;

endmodule

// File: tb/tb_writeback_buffer.sv
// Directed bench for writeback_buffer: vector table plus hand-written sequences
// for backpressure saturation, pointer wrap and mid-stream reset.
module tb_writeback_buffer;

   localparam int DEPTH = 4;
   localparam int AW    = 6;
   localparam int DW    = 32;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clock, reset;
   logic          alu_valid, mem_valid, mem_ready;
   logic [AW-1:0] alu_rd, mem_rd, Read1, Read2, RD;
   logic [DW-1:0] alu_data, mem_data, WriteData, Fwd1Data, Fwd2Data;
   logic          RegWrite, Fwd1Valid, Fwd2Valid;
   logic [CW-1:0] count;

   int total = 0;
   int bad   = 0;

   writeback_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clock(clock), .reset(reset),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
      .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
      .mem_ready(mem_ready),
      .RegWrite(RegWrite), .RD(RD), .WriteData(WriteData),
      .Read1(Read1), .Read2(Read2),
      .Fwd1Valid(Fwd1Valid), .Fwd1Data(Fwd1Data),
      .Fwd2Valid(Fwd2Valid), .Fwd2Data(Fwd2Data),
      .count(count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic          av;
      logic [AW-1:0] ar;
      logic [DW-1:0] ad;
      logic          mv;
      logic [AW-1:0] mr;
      logic [DW-1:0] md;
      logic [AW-1:0] r1, r2;
      logic          e_mrdy;
      logic          e_rw;
      logic [AW-1:0] e_rd;
      logic [DW-1:0] e_wd;
      logic [CW-1:0] e_cnt;
      logic          e_f1v;
      logic [DW-1:0] e_f1d;
      logic          e_f2v;
      logic [DW-1:0] e_f2d;
   } vec_t;

   function automatic vec_t mk(
      input logic av, input int ar, input logic [DW-1:0] ad,
      input logic mv, input int mr, input logic [DW-1:0] md,
      input int r1, input int r2, input logic e_mrdy,
      input logic e_rw, input int e_rd, input logic [DW-1:0] e_wd, input int e_cnt,
      input logic e_f1v, input logic [DW-1:0] e_f1d,
      input logic e_f2v, input logic [DW-1:0] e_f2d);
      vec_t v;
      v.av = av; v.ar = AW'(ar); v.ad = ad;
      v.mv = mv; v.mr = AW'(mr); v.md = md;
      v.r1 = AW'(r1); v.r2 = AW'(r2); v.e_mrdy = e_mrdy;
      v.e_rw = e_rw; v.e_rd = AW'(e_rd); v.e_wd = e_wd; v.e_cnt = CW'(e_cnt);
      v.e_f1v = e_f1v; v.e_f1d = e_f1d; v.e_f2v = e_f2v; v.e_f2d = e_f2d;
      return v;
   endfunction

   task automatic drive(input logic av, input int ar, input logic [DW-1:0] ad,
                        input logic mv, input int mr, input logic [DW-1:0] md);
      alu_valid = av; alu_rd = AW'(ar); alu_data = ad;
      mem_valid = mv; mem_rd = AW'(mr); mem_data = md;
   endtask

   vec_t vecs [15];
   logic [AW-1:0] sat_rd   [8];
   logic [DW-1:0] sat_wd   [8];
   logic          sat_mrdy [5];
   logic [CW-1:0] sat_cnt  [9];

   initial begin
      // expected outputs are those seen one cycle after the inputs of each row
      vecs[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0,       5, 0, 1, 0, 0, 32'h0,        1, 1, 32'hDEADBEEF, 0, 0);
      vecs[1]  = mk(0, 0, 0,            0, 0, 0,       5, 0, 1, 1, 5, 32'hDEADBEEF, 0, 1, 32'hDEADBEEF, 0, 0);
      vecs[2]  = mk(0, 0, 0,            0, 0, 0,       5, 0, 1, 0, 5, 32'hDEADBEEF, 0, 0, 0,            0, 0);
      vecs[3]  = mk(1, 0, 32'h1234,     1, 0, 32'h5555, 0, 0, 1, 0, 5, 32'hDEADBEEF, 0, 0, 0,            0, 0);
      vecs[4]  = mk(1, 4, 32'h22,       1, 3, 32'h11,  3, 4, 1, 0, 5, 32'hDEADBEEF, 2, 1, 32'h11,       1, 32'h22);
      vecs[5]  = mk(0, 0, 0,            0, 0, 0,       3, 4, 1, 1, 3, 32'h11,       1, 1, 32'h11,       1, 32'h22);
      vecs[6]  = mk(0, 0, 0,            0, 0, 0,       3, 4, 1, 1, 4, 32'h22,       0, 0, 0,            1, 32'h22);
      vecs[7]  = mk(0, 0, 0,            0, 0, 0,       3, 4, 1, 0, 4, 32'h22,       0, 0, 0,            0, 0);
      vecs[8]  = mk(1, 7, 32'hA,        0, 0, 0,       7, 0, 1, 0, 4, 32'h22,       1, 1, 32'hA,        0, 0);
      vecs[9]  = mk(1, 7, 32'hB,        0, 0, 0,       7, 0, 1, 1, 7, 32'hA,        1, 1, 32'hB,        0, 0);
      vecs[10] = mk(0, 0, 0,            0, 0, 0,       7, 0, 1, 1, 7, 32'hB,        0, 1, 32'hB,        0, 0);
      vecs[11] = mk(0, 0, 0,            0, 0, 0,       7, 0, 1, 0, 7, 32'hB,        0, 0, 0,            0, 0);
      vecs[12] = mk(1, 9, 32'h99,       1, 0, 32'h77,  9, 0, 1, 0, 7, 32'hB,        1, 1, 32'h99,       0, 0);
      vecs[13] = mk(0, 0, 0,            0, 0, 0,       0, 9, 1, 1, 9, 32'h99,       0, 0, 0,            1, 32'h99);
      vecs[14] = mk(0, 0, 0,            0, 0, 0,       9, 9, 1, 0, 9, 32'h99,       0, 0, 0,            0, 0);

      sat_rd   = '{8, 9, 8, 9, 8, 9, 9, 9};
      sat_wd   = '{32'h800, 32'h900, 32'h801, 32'h901, 32'h802, 32'h902, 32'h903, 32'h904};
      sat_mrdy = '{1, 1, 1, 0, 0};
      sat_cnt  = '{2, 3, 4, 4, 4, 3, 2, 1, 0};

      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      Read1 = '0; Read2 = '0;
      #2;
      check("reset_rw",    64'(RegWrite),  64'd0);
      check("reset_rd",    64'(RD),        64'd0);
      check("reset_wd",    64'(WriteData), 64'd0);
      check("reset_count", 64'(count),     64'd0);
      #10 reset = 1'b0;

      for (int v = 0; v < 15; v++) begin
         drive(vecs[v].av, int'(vecs[v].ar), vecs[v].ad, vecs[v].mv, int'(vecs[v].mr), vecs[v].md);
         Read1 = vecs[v].r1;
         Read2 = vecs[v].r2;
         #1;
         check($sformatf("v%0d_mem_ready", v), 64'(mem_ready), 64'(vecs[v].e_mrdy));
         @(posedge clock);
         #1;
         check($sformatf("v%0d_rw", v),    64'(RegWrite),  64'(vecs[v].e_rw));
         check($sformatf("v%0d_rd", v),    64'(RD),        64'(vecs[v].e_rd));
         check($sformatf("v%0d_wd", v),    64'(WriteData), 64'(vecs[v].e_wd));
         check($sformatf("v%0d_count", v), 64'(count),     64'(vecs[v].e_cnt));
         check($sformatf("v%0d_f1v", v),   64'(Fwd1Valid), 64'(vecs[v].e_f1v));
         check($sformatf("v%0d_f1d", v),   64'(Fwd1Data),  64'(vecs[v].e_f1d));
         check($sformatf("v%0d_f2v", v),   64'(Fwd2Valid), 64'(vecs[v].e_f2v));
         check($sformatf("v%0d_f2d", v),   64'(Fwd2Data),  64'(vecs[v].e_f2d));
      end

      // saturation: both ports every cycle, then drain
      Read1 = '0; Read2 = '0;
      for (int k = 0; k < 9; k++) begin
         if (k < 5) begin
            drive(1, 9, 32'h900 + DW'(k), 1, 8, 32'h800 + DW'(k));
            #1;
            check($sformatf("sat%0d_mem_ready", k), 64'(mem_ready), 64'(sat_mrdy[k]));
         end else begin
            drive(0, 0, 0, 0, 0, 0);
         end
         @(posedge clock);
         #1;
         check($sformatf("sat%0d_count", k), 64'(count), 64'(sat_cnt[k]));
         if (k == 0) begin
            check("sat0_rw", 64'(RegWrite), 64'd0);
         end else begin
            check($sformatf("sat%0d_rw", k), 64'(RegWrite),  64'd1);
            check($sformatf("sat%0d_rd", k), 64'(RD),        64'(sat_rd[k-1]));
            check($sformatf("sat%0d_wd", k), 64'(WriteData), 64'(sat_wd[k-1]));
         end
      end
      @(posedge clock);
      #1;
      check("sat_idle_rw", 64'(RegWrite), 64'd0);

      // wrap-around: ten entries over both ports with idle gaps
      begin
         int next_send = 1;
         int next_exp  = 1;
         for (int cyc = 0; cyc < 60 && next_exp <= 10; cyc++) begin
            if (next_send <= 10 && (cyc % 3) != 2) begin
               if (next_send % 2 == 0)
                  drive(0, 0, 0, 1, next_send, DW'(next_send * 256));
               else
                  drive(1, next_send, DW'(next_send * 256), 0, 0, 0);
               next_send++;
            end else begin
               drive(0, 0, 0, 0, 0, 0);
            end
            @(posedge clock);
            #1;
            if (RegWrite) begin
               check($sformatf("wrap_rd%0d", next_exp), 64'(RD),        64'(next_exp));
               check($sformatf("wrap_wd%0d", next_exp), 64'(WriteData), 64'(next_exp * 256));
               next_exp++;
            end
         end
         check("wrap_writes", 64'(next_exp - 1), 64'd10);
         drive(0, 0, 0, 0, 0, 0);
         @(posedge clock);
         #1;
         check("wrap_idle_rw",    64'(RegWrite), 64'd0);
         check("wrap_idle_count", 64'(count),    64'd0);
      end

      // reset mid-stream with three entries queued and a write in the output stage
      drive(1, 21, 32'h2100, 1, 20, 32'h2000);
      @(posedge clock);
      @(posedge clock);
      #1;
      drive(0, 0, 0, 0, 0, 0);
      check("pre_reset_count", 64'(count),    64'd3);
      check("pre_reset_rw",    64'(RegWrite), 64'd1);
      #2 reset = 1'b1;
      #1;
      check("midreset_rw",    64'(RegWrite),  64'd0);
      check("midreset_rd",    64'(RD),        64'd0);
      check("midreset_wd",    64'(WriteData), 64'd0);
      check("midreset_count", 64'(count),     64'd0);
      #2 reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clock);
         #1;
         check($sformatf("post_reset%0d_rw", k),    64'(RegWrite), 64'd0);
         check($sformatf("post_reset%0d_count", k), 64'(count),    64'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
